// File: rtl/serdesphy_clock_sequencer.sv
// rtl/serdesphy_clock_sequencer.sv - PHY PLL/CDR lock qualifier and 24M/240M clock-enable sequencer
// One instance per PHY; all outputs are registered from the next-state values.
module serdesphy_clock_sequencer #(
    parameter int NUM_LANES           = 2,
    parameter int CNT_W               = 12,
    parameter int PLL_LOCK_CYCLES     = 240,
    parameter int CDR_LOCK_CYCLES     = 1200,
    parameter int LOCK_TIMEOUT_CYCLES = 4000
) (
    input  logic                 clk_ref_24m,
    input  logic                 rst,
    input  logic                 phy_en,
    input  logic                 pll_rst,
    input  logic [NUM_LANES-1:0] cdr_rst,
    input  logic [NUM_LANES-1:0] lane_en,
    input  logic                 err_clr,
    input  logic                 pll_lock_raw,
    input  logic [NUM_LANES-1:0] cdr_lock_raw,
    output logic                 clk_24m_en,
    output logic                 clk_240m_tx_en,
    output logic [NUM_LANES-1:0] clk_240m_rx_en,
    output logic                 pll_lock,
    output logic [NUM_LANES-1:0] cdr_lock,
    output logic                 phy_ready,
    output logic [2:0]           seq_state,
    output logic                 err_pll_timeout,
    output logic                 err_cdr_timeout,
    output logic                 pll_lost,
    output logic [NUM_LANES-1:0] cdr_lost
);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_PLL_WAIT = 3'd1,
        ST_CDR_WAIT = 3'd2,
        ST_READY    = 3'd3,
        ST_FAULT    = 3'd4
    } seq_state_t;

    localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CDR_LAST = CNT_W'(CDR_LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    seq_state_t           state_q, state_d;
    logic                 pll_lock_q, pll_lock_d;
    logic [NUM_LANES-1:0] cdr_lock_q, cdr_lock_d;
    logic [CNT_W-1:0]     qcnt_q, qcnt_d;
    logic [CNT_W-1:0]     tcnt_q, tcnt_d;
    logic [CNT_W-1:0]     ccnt_q [NUM_LANES];
    logic [CNT_W-1:0]     ccnt_d [NUM_LANES];

    logic                 set_pll_to, set_cdr_to, set_pll_lost;
    logic [NUM_LANES-1:0] set_cdr_lost;

    logic [NUM_LANES-1:0] lane_lock_c, lane_loss_c;
    logic [CNT_W-1:0]     lane_cnt_c [NUM_LANES];
    logic                 all_locked;
    logic                 pll_hit, tmo_hit;
    logic [CNT_W-1:0]     qcnt_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Per-lane qualification as it would apply while the PLL is locked
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_lock_c[i] = cdr_lock_q[i];
            lane_cnt_c[i]  = ccnt_q[i];
            lane_loss_c[i] = 1'b0;
            if (!lane_en[i] || cdr_rst[i]) begin
                lane_lock_c[i] = 1'b0;
                lane_cnt_c[i]  = '0;
            end else if (!cdr_lock_raw[i]) begin
                lane_loss_c[i] = cdr_lock_q[i];
                lane_lock_c[i] = 1'b0;
                lane_cnt_c[i]  = '0;
            end else begin
                if (!cdr_lock_q[i] && ccnt_q[i] == CDR_LAST)
                    lane_lock_c[i] = 1'b1;
                lane_cnt_c[i] = sat_inc(ccnt_q[i]);
            end
        end
    end

    assign all_locked = &(lane_lock_c | ~lane_en);
    assign pll_hit    = pll_lock_raw && (qcnt_q == PLL_LAST);
    assign tmo_hit    = (tcnt_q == TMO_LAST);
    assign qcnt_inc   = pll_lock_raw ? sat_inc(qcnt_q) : '0;

    always_comb begin
        state_d      = state_q;
        pll_lock_d   = pll_lock_q;
        cdr_lock_d   = cdr_lock_q;
        qcnt_d       = qcnt_q;
        tcnt_d       = tcnt_q;
        for (int i = 0; i < NUM_LANES; i++) ccnt_d[i] = ccnt_q[i];
        set_pll_to   = 1'b0;
        set_cdr_to   = 1'b0;
        set_pll_lost = 1'b0;
        set_cdr_lost = '0;

        if (!phy_en) begin
            state_d    = ST_OFF;
            pll_lock_d = 1'b0;
            cdr_lock_d = '0;
            qcnt_d     = '0;
            tcnt_d     = '0;
            for (int i = 0; i < NUM_LANES; i++) ccnt_d[i] = '0;
        end else if (pll_rst && state_q != ST_OFF) begin
            state_d    = ST_PLL_WAIT;
            pll_lock_d = 1'b0;
            cdr_lock_d = '0;
            qcnt_d     = '0;
            tcnt_d     = '0;
            for (int i = 0; i < NUM_LANES; i++) ccnt_d[i] = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (!pll_rst) begin
                        state_d = ST_PLL_WAIT;
                        qcnt_d  = '0;
                        tcnt_d  = '0;
                    end
                end
                ST_PLL_WAIT: begin
                    qcnt_d = qcnt_inc;
                    if (pll_hit) begin
                        pll_lock_d = 1'b1;
                        state_d    = ST_CDR_WAIT;
                        tcnt_d     = '0;
                        for (int i = 0; i < NUM_LANES; i++) ccnt_d[i] = '0;
                    end else if (tmo_hit) begin
                        state_d    = ST_FAULT;
                        set_pll_to = 1'b1;
                    end else begin
                        tcnt_d = sat_inc(tcnt_q);
                    end
                end
                ST_CDR_WAIT, ST_READY: begin
                    if (!pll_lock_raw) begin
                        // PLL loss outranks every lane event
                        state_d      = ST_PLL_WAIT;
                        pll_lock_d   = 1'b0;
                        cdr_lock_d   = '0;
                        qcnt_d       = '0;
                        tcnt_d       = '0;
                        set_pll_lost = 1'b1;
                        for (int i = 0; i < NUM_LANES; i++) ccnt_d[i] = '0;
                    end else begin
                        cdr_lock_d   = lane_lock_c;
                        set_cdr_lost = lane_loss_c;
                        for (int i = 0; i < NUM_LANES; i++) ccnt_d[i] = lane_cnt_c[i];
                        if (state_q == ST_CDR_WAIT) begin
                            if (all_locked) begin
                                state_d = ST_READY;
                            end else if (tmo_hit) begin
                                state_d    = ST_FAULT;
                                set_cdr_to = 1'b1;
                                pll_lock_d = 1'b0;
                                cdr_lock_d = '0;
                                for (int i = 0; i < NUM_LANES; i++) ccnt_d[i] = '0;
                            end else begin
                                tcnt_d = sat_inc(tcnt_q);
                            end
                        end else if (!all_locked) begin
                            state_d = ST_CDR_WAIT;
                            tcnt_d  = '0;
                        end
                    end
                end
                ST_FAULT: begin
                    if (err_clr) begin
                        state_d = ST_PLL_WAIT;
                        qcnt_d  = '0;
                        tcnt_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk_ref_24m or posedge rst) begin
        if (rst) begin
            state_q    <= ST_OFF;
            pll_lock_q <= 1'b0;
            cdr_lock_q <= '0;
            qcnt_q     <= '0;
            tcnt_q     <= '0;
            for (int i = 0; i < NUM_LANES; i++) ccnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            pll_lock_q <= pll_lock_d;
            cdr_lock_q <= cdr_lock_d;
            qcnt_q     <= qcnt_d;
            tcnt_q     <= tcnt_d;
            for (int i = 0; i < NUM_LANES; i++) ccnt_q[i] <= ccnt_d[i];
        end
    end

    // Sticky flags: a set on the same edge as err_clr wins
    always_ff @(posedge clk_ref_24m or posedge rst) begin
        if (rst) begin
            err_pll_timeout <= 1'b0;
            err_cdr_timeout <= 1'b0;
            pll_lost        <= 1'b0;
            cdr_lost        <= '0;
            clk_24m_en      <= 1'b0;
            clk_240m_tx_en  <= 1'b0;
            clk_240m_rx_en  <= '0;
            phy_ready       <= 1'b0;
        end else begin
            err_pll_timeout <= set_pll_to | (err_pll_timeout & ~err_clr);
            err_cdr_timeout <= set_cdr_to | (err_cdr_timeout & ~err_clr);
            pll_lost        <= set_pll_lost | (pll_lost & ~err_clr);
            cdr_lost        <= set_cdr_lost | (cdr_lost & {NUM_LANES{~err_clr}});
            clk_24m_en      <= (state_d != ST_OFF);
            clk_240m_tx_en  <= pll_lock_d;
            clk_240m_rx_en  <= {NUM_LANES{pll_lock_d}} & cdr_lock_d & lane_en;
            phy_ready       <= (state_d == ST_READY);
        end
    end

    assign pll_lock  = pll_lock_q;
    assign cdr_lock  = cdr_lock_q;
    assign seq_state = state_q;

endmodule

// File: tb/tb_serdesphy_clock_sequencer.sv
// tb/tb_serdesphy_clock_sequencer.sv - directed scoreboard bench for serdesphy_clock_sequencer
module tb_serdesphy_clock_sequencer;

    logic       clk_ref_24m = 1'b0;
    logic       rst;
    logic       phy_en, pll_rst, err_clr, pll_lock_raw;
    logic [1:0] cdr_rst, lane_en, cdr_lock_raw;
    logic       clk_24m_en, clk_240m_tx_en, pll_lock, phy_ready;
    logic       err_pll_timeout, err_cdr_timeout, pll_lost;
    logic [1:0] clk_240m_rx_en, cdr_lock, cdr_lost;
    logic [2:0] seq_state;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } exp_t;
    exp_t sb[$];

    serdesphy_clock_sequencer #(
        .NUM_LANES(2), .CNT_W(12), .PLL_LOCK_CYCLES(4),
        .CDR_LOCK_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32)
    ) dut (
        .clk_ref_24m(clk_ref_24m), .rst(rst), .phy_en(phy_en), .pll_rst(pll_rst),
        .cdr_rst(cdr_rst), .lane_en(lane_en), .err_clr(err_clr),
        .pll_lock_raw(pll_lock_raw), .cdr_lock_raw(cdr_lock_raw),
        .clk_24m_en(clk_24m_en), .clk_240m_tx_en(clk_240m_tx_en),
        .clk_240m_rx_en(clk_240m_rx_en), .pll_lock(pll_lock), .cdr_lock(cdr_lock),
        .phy_ready(phy_ready), .seq_state(seq_state),
        .err_pll_timeout(err_pll_timeout), .err_cdr_timeout(err_cdr_timeout),
        .pll_lost(pll_lost), .cdr_lost(cdr_lost)
    );

    always #5 clk_ref_24m = ~clk_ref_24m;

    function automatic logic [15:0] pk(input logic c24, input logic tx, input logic [1:0] rx,
                                       input logic pl, input logic [1:0] cl, input logic rdy,
                                       input logic [2:0] st, input logic ept, input logic ect,
                                       input logic pls, input logic [1:0] cls);
        return {c24, tx, rx, pl, cl, rdy, st, ept, ect, pls, cls};
    endfunction

    function automatic logic [15:0] observed();
        return {clk_24m_en, clk_240m_tx_en, clk_240m_rx_en, pll_lock, cdr_lock, phy_ready,
                seq_state, err_pll_timeout, err_cdr_timeout, pll_lost, cdr_lost};
    endfunction

    task automatic compare_head();
        exp_t e;
        logic [15:0] obs;
        e   = sb.pop_front();
        obs = observed();
        n_assert++;
        assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    // push expectation, advance n rising edges, sample on the following falling edge
    task automatic expect_after(input int n, input string tag, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
        repeat (n) @(posedge clk_ref_24m);
        @(negedge clk_ref_24m);
        compare_head();
    endtask

    initial begin
        rst = 1'b1; phy_en = 1'b0; pll_rst = 1'b0; err_clr = 1'b0; pll_lock_raw = 1'b0;
        cdr_rst = 2'b00; lane_en = 2'b00; cdr_lock_raw = 2'b00;
        repeat (2) @(negedge clk_ref_24m);
        expect_after(0, "reset", pk(0,0,2'b00,0,2'b00,0,3'd0,0,0,0,2'b00));

        // bring-up with both lanes
        rst = 1'b0; phy_en = 1'b1; lane_en = 2'b11; pll_lock_raw = 1'b1; cdr_lock_raw = 2'b11;
        expect_after(1, "edge1_pll_wait", pk(1,0,2'b00,0,2'b00,0,3'd1,0,0,0,2'b00));
        expect_after(3, "edge4_no_lock",  pk(1,0,2'b00,0,2'b00,0,3'd1,0,0,0,2'b00));
        expect_after(1, "edge5_pll_lock", pk(1,1,2'b00,1,2'b00,0,3'd2,0,0,0,2'b00));
        expect_after(7, "edge12_no_cdr",  pk(1,1,2'b00,1,2'b00,0,3'd2,0,0,0,2'b00));
        expect_after(1, "edge13_ready",   pk(1,1,2'b11,1,2'b11,1,3'd3,0,0,0,2'b00));

        // lane 1 loss and recovery
        cdr_lock_raw = 2'b01;
        expect_after(1, "lane1_loss",     pk(1,1,2'b01,1,2'b01,0,3'd2,0,0,0,2'b10));
        cdr_lock_raw = 2'b11;
        expect_after(7, "lane1_requal",   pk(1,1,2'b01,1,2'b01,0,3'd2,0,0,0,2'b10));
        expect_after(1, "lane1_ready",    pk(1,1,2'b11,1,2'b11,1,3'd3,0,0,0,2'b10));

        // PLL loss from READY
        pll_lock_raw = 1'b0;
        expect_after(1, "pll_loss",       pk(1,0,2'b00,0,2'b00,0,3'd1,0,0,1,2'b10));

        // glitch restarts PLL qualification
        pll_lock_raw = 1'b1;
        expect_after(3, "pll_3high",      pk(1,0,2'b00,0,2'b00,0,3'd1,0,0,1,2'b10));
        pll_lock_raw = 1'b0;
        expect_after(1, "pll_glitch",     pk(1,0,2'b00,0,2'b00,0,3'd1,0,0,1,2'b10));
        pll_lock_raw = 1'b1;
        expect_after(3, "pll_3_after",    pk(1,0,2'b00,0,2'b00,0,3'd1,0,0,1,2'b10));
        expect_after(1, "pll_4_after",    pk(1,1,2'b00,1,2'b00,0,3'd2,0,0,1,2'b10));

        // pll_rst forces and holds PLL_WAIT without timing out
        pll_rst = 1'b1;
        expect_after(1, "pll_rst",        pk(1,0,2'b00,0,2'b00,0,3'd1,0,0,1,2'b10));
        expect_after(40, "pll_rst_hold",  pk(1,0,2'b00,0,2'b00,0,3'd1,0,0,1,2'b10));

        // PLL timeout
        pll_rst = 1'b0; pll_lock_raw = 1'b0;
        expect_after(31, "pll_tmo_edge",  pk(1,0,2'b00,0,2'b00,0,3'd1,0,0,1,2'b10));
        expect_after(1, "pll_tmo_fault",  pk(1,0,2'b00,0,2'b00,0,3'd4,1,0,1,2'b10));
        expect_after(5, "fault_hold",     pk(1,0,2'b00,0,2'b00,0,3'd4,1,0,1,2'b10));
        err_clr = 1'b1;
        expect_after(1, "err_clr",        pk(1,0,2'b00,0,2'b00,0,3'd1,0,0,0,2'b00));
        err_clr = 1'b0;

        // CDR timeout
        pll_lock_raw = 1'b1; cdr_lock_raw = 2'b00;
        expect_after(4, "cdr_wait",       pk(1,1,2'b00,1,2'b00,0,3'd2,0,0,0,2'b00));
        expect_after(31, "cdr_tmo_edge",  pk(1,1,2'b00,1,2'b00,0,3'd2,0,0,0,2'b00));
        expect_after(1, "cdr_tmo_fault",  pk(1,0,2'b00,0,2'b00,0,3'd4,0,1,0,2'b00));

        // phy_en low keeps sticky flags
        phy_en = 1'b0;
        expect_after(1, "phy_off",        pk(0,0,2'b00,0,2'b00,0,3'd0,0,1,0,2'b00));

        // single enabled lane
        phy_en = 1'b1; lane_en = 2'b01; cdr_lock_raw = 2'b01;
        expect_after(1, "l0_pll_wait",    pk(1,0,2'b00,0,2'b00,0,3'd1,0,1,0,2'b00));
        expect_after(4, "l0_cdr_wait",    pk(1,1,2'b00,1,2'b00,0,3'd2,0,1,0,2'b00));
        expect_after(7, "l0_edge12",      pk(1,1,2'b00,1,2'b00,0,3'd2,0,1,0,2'b00));
        expect_after(1, "l0_ready",       pk(1,1,2'b01,1,2'b01,1,3'd3,0,1,0,2'b00));
        cdr_lock_raw = 2'b00;
        expect_after(1, "l0_loss",        pk(1,1,2'b00,1,2'b00,0,3'd2,0,1,0,2'b01));
        expect_after(3, "l0_cdr_wait2",   pk(1,1,2'b00,1,2'b00,0,3'd2,0,1,0,2'b01));

        // asynchronous reset mid CDR_WAIT
        begin
            exp_t e;
            e.tag = "async_rst";
            e.exp = pk(0,0,2'b00,0,2'b00,0,3'd0,0,0,0,2'b00);
            sb.push_back(e);
            rst = 1'b1;
            #1;
            compare_head();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
